// File: rtl/reg_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_fifo_pkg
// Description : Shared constants and helpers for the register-stage FIFO.
//               The default data width is shared with the upstream register
//               stage so both sides agree on the word size.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_fifo_pkg;

    // Word width of the upstream register stage and of the FIFO entries.
    localparam int c_DEFAULT_N     = 8;

    // Default number of FIFO entries (power of two, at least 2).
    localparam int c_DEFAULT_DEPTH = 4;

    // Ceiling log2, usable in constant expressions on flows lacking $clog2.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage : reg_fifo_pkg
`default_nettype wire

// File: rtl/reg_fifo_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ptr_ctrl
// Description : Pointer and occupancy control for reg_fifo. Decides which
//               write/read requests are accepted, advances the circular
//               pointers and tracks the number of stored words.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ptr_ctrl
    import reg_fifo_pkg::*;
#(
    parameter int DEPTH = c_DEFAULT_DEPTH,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic          rd_en,
    output logic [AW-1:0] wr_ptr,
    output logic [AW-1:0] rd_ptr,
    output logic [AW:0]   count,
    output logic          wr_acc,
    output logic          rd_acc,
    output logic          full,
    output logic          empty
);

    // Occupancy value that marks the FIFO as full.
    localparam logic [AW:0] c_FULL_COUNT = (AW+1)'(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_full;
    logic          w_empty;
    logic          w_wr_acc;
    logic          w_rd_acc;

    // Flags decode straight from the registered count, so they only change
    // right after a clock edge. A write into a full FIFO is still allowed
    // when a read frees a slot on the same edge.
    always_comb begin
        w_full   = (r_count == c_FULL_COUNT);
        w_empty  = (r_count == '0);
        w_rd_acc = rd_en && !w_empty;
        w_wr_acc = wr_en && (!w_full || w_rd_acc);
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy moves only when exactly one side is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign wr_ptr = r_wr_ptr;
    assign rd_ptr = r_rd_ptr;
    assign count  = r_count;
    assign wr_acc = w_wr_acc;
    assign rd_acc = w_rd_acc;
    assign full   = w_full;
    assign empty  = w_empty;

endmodule : fifo_ptr_ctrl
`default_nettype wire

// File: rtl/reg_fifo.sv
`default_nettype none
// ============================================================================
// Module      : reg_fifo
// Description : Synchronous FIFO buffering register-stage output words for a
//               slower consumer. Registered read data (one-cycle latency,
//               not first-word-fall-through), full/empty flags, occupancy
//               count and one-cycle overflow/underflow pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_fifo
    import reg_fifo_pkg::*;
#(
    parameter  int N     = c_DEFAULT_N,
    parameter  int DEPTH = c_DEFAULT_DEPTH,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [N-1:0] din,
    input  logic         rd_en,
    output logic [N-1:0] dout,
    output logic         dout_valid,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count,
    output logic         ovf,
    output logic         udf
);

    logic [AW-1:0] w_wr_ptr;
    logic [AW-1:0] w_rd_ptr;
    logic          w_wr_acc;
    logic          w_rd_acc;

    logic [N-1:0]  r_mem [DEPTH];
    logic [N-1:0]  r_dout;
    logic          r_dout_valid;
    logic          r_ovf;
    logic          r_udf;

    fifo_ptr_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ptr_ctrl (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .wr_ptr (w_wr_ptr),
        .rd_ptr (w_rd_ptr),
        .count  (count),
        .wr_acc (w_wr_acc),
        .rd_acc (w_rd_acc),
        .full   (full),
        .empty  (empty)
    );

    // Storage has no reset; stale contents are never visible because the
    // read side only consumes slots that were written since reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[w_wr_ptr] <= din;
        end
    end

    // Read register: captures the oldest word on an accepted read and holds
    // it otherwise. When full with a simultaneous read and write, the two
    // pointers hit the same slot and the old word is captured before it is
    // overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_dout <= r_mem[w_rd_ptr];
            end
        end
    end

    // Error pulses flag requests rejected on the previous edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= wr_en && !w_wr_acc;
            r_udf <= rd_en && !w_rd_acc;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign ovf        = r_ovf;
    assign udf        = r_udf;

endmodule : reg_fifo
`default_nettype wire

// File: tb/tb_reg_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_fifo
// Description : Self-checking bench for reg_fifo with a queue-based
//               reference model, directed boundary scenarios and random
//               traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_fifo;

    localparam int N     = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [N-1:0]  din;
    logic          rd_en;
    logic [N-1:0]  dout;
    logic          dout_valid;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          ovf;
    logic          udf;

    int n_tests;
    int n_fail;

    // Reference model state
    logic [N-1:0] model_q[$];
    logic [N-1:0] exp_dout;
    logic         exp_dv;
    logic         exp_ovf;
    logic         exp_udf;

    reg_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .din        (din),
        .rd_en      (rd_en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .ovf        (ovf),
        .udf        (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".count"},      32'(count),      32'(model_q.size()));
        check_eq({tag, ".full"},       32'(full),       32'(model_q.size() == DEPTH));
        check_eq({tag, ".empty"},      32'(empty),      32'(model_q.size() == 0));
        check_eq({tag, ".dout"},       32'(dout),       32'(exp_dout));
        check_eq({tag, ".dout_valid"}, 32'(dout_valid), 32'(exp_dv));
        check_eq({tag, ".ovf"},        32'(ovf),        32'(exp_ovf));
        check_eq({tag, ".udf"},        32'(udf),        32'(exp_udf));
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_dout = '0;
        exp_dv   = 1'b0;
        exp_ovf  = 1'b0;
        exp_udf  = 1'b0;
    endtask

    // One clock: apply inputs, let the model decide from the pre-edge
    // occupancy, then compare #1 after the edge.
    task automatic cycle(input string tag, input logic w, input logic [N-1:0] d, input logic r);
        bit rd_ok;
        bit wr_ok;
        wr_en = w;
        din   = d;
        rd_en = r;
        rd_ok = r && (model_q.size() > 0);
        wr_ok = w && ((model_q.size() < DEPTH) || rd_ok);
        @(posedge clk);
        #1;
        if (rd_ok) begin
            exp_dout = model_q.pop_front();
        end
        if (wr_ok) begin
            model_q.push_back(d);
        end
        exp_dv  = rd_ok;
        exp_ovf = w && !wr_ok;
        exp_udf = r && !rd_ok;
        check_all(tag);
    endtask

    initial begin
        logic [N-1:0] upstream_q;
        n_tests = 0;
        n_fail  = 0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        din     = '0;
        rst_n   = 1'b0;
        model_reset();

        // Reset then idle
        #1;
        check_all("reset");
        #21;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_release");
        for (int i = 0; i < 10; i++) begin
            cycle("idle", 1'b0, '0, 1'b0);
        end

        // Fill and drain in order
        for (int i = 1; i <= 4; i++) begin
            cycle("fill", 1'b1, N'(i), 1'b0);
        end
        check_eq("fill.full_flag", 32'(full), 32'd1);
        check_eq("fill.count4", 32'(count), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            cycle("drain", 1'b0, '0, 1'b1);
            check_eq("drain.word", 32'(dout), 32'(i));
        end
        check_eq("drain.empty_end", 32'(empty), 32'd1);

        // Overflow while full, underflow while empty
        for (int i = 0; i < 4; i++) begin
            cycle("refill", 1'b1, N'(8'h50 + i), 1'b0);
        end
        cycle("ovf", 1'b1, 8'hAA, 1'b0);
        check_eq("ovf.pulse", 32'(ovf), 32'd1);
        cycle("ovf_clear", 1'b0, '0, 1'b0);
        check_eq("ovf.not_sticky", 32'(ovf), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle("ovf_drain", 1'b0, '0, 1'b1);
            check_eq("ovf_drain.word", 32'(dout), 32'(8'h50 + i));
        end
        cycle("udf", 1'b0, '0, 1'b1);
        check_eq("udf.pulse", 32'(udf), 32'd1);
        check_eq("udf.dout_held", 32'(dout), 32'h53);

        // Simultaneous read/write at full
        for (int i = 0; i < 4; i++) begin
            cycle("fill_sim", 1'b1, N'(8'h60 + i), 1'b0);
        end
        cycle("sim_full", 1'b1, 8'h10, 1'b1);
        check_eq("sim_full.oldest", 32'(dout), 32'h60);
        check_eq("sim_full.count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            cycle("sim_full_drain", 1'b0, '0, 1'b1);
        end
        check_eq("sim_full.last", 32'(dout), 32'h10);

        // Simultaneous read/write at empty
        cycle("sim_empty", 1'b1, 8'h20, 1'b1);
        check_eq("sim_empty.udf", 32'(udf), 32'd1);
        check_eq("sim_empty.count", 32'(count), 32'd1);
        cycle("sim_empty_rd", 1'b0, '0, 1'b1);
        check_eq("sim_empty.word", 32'(dout), 32'h20);

        // Upstream register counts 0x00..0x0B, changing every two clocks;
        // each new value is written, then read back, across pointer wraps.
        upstream_q = '0;
        for (int k = 0; k < 12; k++) begin
            cycle("wrap_wr", 1'b1, upstream_q, 1'b0);
            cycle("wrap_rd", 1'b0, '0, 1'b1);
            check_eq("wrap.order", 32'(dout), 32'(k));
            upstream_q = upstream_q + 1'b1;
        end

        // Asynchronous reset mid-stream with three words stored
        for (int i = 0; i < 4; i++) begin
            cycle("pre_rst", 1'b1, N'(8'h70 + i), 1'b0);
        end
        cycle("pre_rst_rd", 1'b0, '0, 1'b1);
        check_eq("pre_rst.count3", 32'(count), 32'd3);
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        #3;
        rst_n = 1'b1;
        cycle("rst_release", 1'b0, '0, 1'b0);
        cycle("rst_first_rd", 1'b0, '0, 1'b1);
        check_eq("rst.first_udf", 32'(udf), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle("rand", 1'($urandom_range(0, 1)), N'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_reg_fifo
`default_nettype wire
